btb_update_ctrl: RTL and testbench
==================================

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of update-buffer entries; a power of 2 and at least 2.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the drop counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports ex_valid (in, 1), ex_ready (out, 1), ex_pc (in, 32) and ex_target (in, 32): taken-branch resolution from EX.
REQ-006 SHALL have ports id_valid (in, 1), id_ready (out, 1), id_pc (in, 32) and id_target (in, 32): JAL resolution from ID.
REQ-007 SHALL have port wr_hold, input, 1 bit: BTB write port unavailable this cycle.
REQ-008 SHALL have port flush, input, 1 bit: discard all buffered updates.
REQ-009 SHALL have ports btb_wr_valid (out, 1), btb_wr_pc (out, 32) and btb_wr_target (out, 32), driving the BTB update port (valid_in, branch_PC, branch_target).
REQ-010 SHALL have port fifo_count, output, clog2(FIFO_DEPTH+1) bits: number of buffered entries.
REQ-011 SHALL have port drop_cnt, output, CNT_WIDTH bits: number of suppressed duplicate updates.

Function
REQ-012 The block SHALL accept a request when valid && ready are both high at a rising edge; at most one request SHALL be accepted per cycle.
REQ-013 Grant: if only one requester is valid, that requester SHALL be granted; if both are valid, the requester selected by rr_ptr SHALL be granted.
REQ-014 rr_ptr SHALL toggle to the other requester after every accepted request and SHALL otherwise hold.
REQ-015 ex_ready/id_ready SHALL be high only when that requester is granted && fifo_count < FIFO_DEPTH && !flush; they are combinational and SHALL NOT depend on wr_hold or on a same-cycle pop.
REQ-016 An accepted request SHALL push {pc, target} at the FIFO tail, unless it is suppressed under REQ-027.
REQ-017 Pop: at each rising edge with fifo_count > 0 && !wr_hold && !flush, the head SHALL be popped, btb_wr_valid set to 1 for exactly one cycle, and btb_wr_pc/btb_wr_target set to the head fields.
REQ-018 btb_wr_valid SHALL be 0 after every edge without a pop; btb_wr_pc/btb_wr_target SHALL hold their last values.
REQ-019 Latency: a request accepted at edge N into an empty FIFO SHALL appear on the btb_wr_* outputs after edge N+1, and the BTB SHALL be written at edge N+2.
REQ-020 A push and a pop in the same cycle SHALL leave fifo_count unchanged; FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 Order: entries SHALL leave the FIFO in acceptance order; pc[1:0] SHALL be passed through unmodified.
REQ-022 Flush at an edge SHALL set fifo_count and both FIFO pointers to 0 and btb_wr_valid to 0, and accept nothing; rr_ptr and drop_cnt SHALL hold.
REQ-023 wr_hold held indefinitely SHALL stall pops without data loss; once the FIFO is full, both readies SHALL be low.

Reset
REQ-024 When rst is low, the block SHALL asynchronously clear fifo_count, both FIFO pointers, btb_wr_valid, btb_wr_pc, btb_wr_target and drop_cnt to 0, and set rr_ptr to EX.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries; after reset release, no btb_wr_valid SHALL be asserted until a new request is accepted.

Configuration
REQ-026 Macro BTB_UPD_DEDUP_EN SHALL compile duplicate suppression in or out.
REQ-027 With BTB_UPD_DEDUP_EN defined: the block SHALL keep a last-pushed {valid, pc, target} register; an accepted request whose pc and target both equal a valid last-pushed entry SHALL complete its handshake without a push, and drop_cnt SHALL increment, saturating at all-ones; the last-pushed valid bit SHALL be cleared by reset and by flush.
REQ-028 Without BTB_UPD_DEDUP_EN: every accepted request SHALL be pushed, drop_cnt SHALL be tied to 0, and no last-pushed register SHALL exist.

Verification
REQ-029 Single request: ex_valid for 1 cycle with pc=0x80000010, target=0x80000100 -> btb_wr_valid high for exactly 1 cycle, 2 edges after acceptance, carrying those values.
REQ-030 Contention: ex and id both valid for 4 cycles with distinct pcs, rr_ptr=EX -> accepts alternate EX, ID, EX, ID, and the BTB writes occur in that order.
REQ-031 Full/hold: wr_hold=1, 6 EX requests -> 4 accepted, fifo_count=4, ex_ready=0; release wr_hold -> 4 consecutive btb_wr_valid pulses, then readies return high.
REQ-032 Flush: 3 entries buffered with wr_hold=1, then flush=1 for 1 cycle -> fifo_count=0, no btb_wr_valid pulse after wr_hold is released.
REQ-033 Reset mid-stream: rst low asynchronously while 2 entries are buffered -> all outputs 0 immediately, and no write after reset release.
REQ-034 Dedup (macro defined): same pc/target accepted twice back-to-back -> one BTB write, drop_cnt=1; with the macro undefined -> two BTB writes, drop_cnt=0.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl
// Arbitrates BTB updates from two producers (taken branches resolved in EX,
// JALs resolved in ID) and queues them in a small FIFO. The FIFO drains into
// the single BTB write port whenever that port is free.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   ex_valid/ex_ready/ex_pc/ex_target   EX update request (valid/ready)
//   id_valid/id_ready/id_pc/id_target   ID update request (valid/ready)
//   wr_hold                    BTB write port busy; stalls draining
//   flush                      discard all buffered updates
//   btb_wr_valid/_pc/_target   registered BTB write request, one-cycle pulse
//   fifo_count                 number of buffered entries
//   drop_cnt                   number of suppressed duplicate updates
//
// Build option
//   BTB_UPD_DEDUP_EN  when defined, a request identical to the most recently
//                     pushed entry is accepted but not queued, and counted in
//                     drop_cnt (saturating). When undefined, drop_cnt is 0.
module btb_update_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ex_valid,
  output logic                             ex_ready,
  input  logic [31:0]                      ex_pc,
  input  logic [31:0]                      ex_target,
  input  logic                             id_valid,
  output logic                             id_ready,
  input  logic [31:0]                      id_pc,
  input  logic [31:0]                      id_target,
  input  logic                             wr_hold,
  input  logic                             flush,
  output logic                             btb_wr_valid,
  output logic [31:0]                      btb_wr_pc,
  output logic [31:0]                      btb_wr_target,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic [CNT_WIDTH-1:0]             drop_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic {ReqEx = 1'b0, ReqId = 1'b1} req_e;

  req_e            rr_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [63:0]     mem_q [FIFO_DEPTH];
  logic            wr_valid_q;
  logic [31:0]     wr_pc_q, wr_target_q;

  logic        grant_ex, grant_id, has_room, accept, push, pop, dup;
  logic [63:0] req_entry;

  // Round-robin only matters when both producers request together.
  assign grant_ex  = ex_valid & (~id_valid | (rr_q == ReqEx));
  assign grant_id  = id_valid & (~ex_valid | (rr_q == ReqId));
  // Readiness deliberately ignores a same-cycle pop to keep ready off the
  // wr_hold path.
  assign has_room  = (count_q < FullCnt) & ~flush;
  assign ex_ready  = grant_ex & has_room;
  assign id_ready  = grant_id & has_room;
  assign accept    = (ex_valid & ex_ready) | (id_valid & id_ready);
  assign req_entry = grant_ex ? {ex_pc, ex_target} : {id_pc, id_target};
  assign pop       = (count_q != '0) & ~wr_hold & ~flush;
  assign push      = accept & ~dup;

`ifdef BTB_UPD_DEDUP_EN
  logic                 last_valid_q;
  logic [63:0]          last_entry_q;
  logic [CNT_WIDTH-1:0] drop_q;

  assign dup      = last_valid_q & (last_entry_q == req_entry);
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_valid_q <= 1'b0;
      last_entry_q <= '0;
      drop_q       <= '0;
    end else if (flush) begin
      last_valid_q <= 1'b0;
    end else begin
      if (push) begin
        last_valid_q <= 1'b1;
        last_entry_q <= req_entry;
      end
      if (accept && dup && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end
`else
  assign dup      = 1'b0;
  assign drop_cnt = '0;
`endif

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q        <= ReqEx;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_valid_q  <= 1'b0;
      wr_pc_q     <= '0;
      wr_target_q <= '0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        rr_q <= (rr_q == ReqEx) ? ReqId : ReqEx;
      end
      // Power-of-two depth: pointers wrap naturally.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        wr_pc_q     <= mem_q[rd_ptr_q][63:32];
        wr_target_q <= mem_q[rd_ptr_q][31:0];
      end
      wr_valid_q <= pop;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign btb_wr_valid  = wr_valid_q;
  assign btb_wr_pc     = wr_pc_q;
  assign btb_wr_target = wr_target_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;
  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 16;
  localparam longint unsigned MaxDrop = (64'd1 << CntW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, id_valid = 1'b0, wr_hold = 1'b0, flush = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, id_pc = '0, id_target = '0;
  logic        ex_ready, id_ready, btb_wr_valid;
  logic [31:0] btb_wr_pc, btb_wr_target;
  logic [2:0]  fifo_count;
  logic [15:0] drop_cnt;

  btb_update_ctrl #(.FIFO_DEPTH(Depth), .CNT_WIDTH(CntW)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_target(ex_target),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_target(id_target),
    .wr_hold(wr_hold), .flush(flush),
    .btb_wr_valid(btb_wr_valid), .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_pulses = 0;
  logic s_ex_rdy, s_id_rdy;

  // Reference model: a queue of {pc, target} plus arbitration/dedup state.
  logic [63:0]     m_q[$];
  int              m_rr;  // 0 = EX preferred, 1 = ID preferred
  longint unsigned m_drop;
  logic            m_wv;
  logic [31:0]     m_pc, m_tgt;
`ifdef BTB_UPD_DEDUP_EN
  logic            m_last_v;
  logic [63:0]     m_last;
`endif

  typedef struct {
    logic ev; logic [31:0] ep, et;
    logic iv; logic [31:0] ip, it;
    logic rex, rid, wv; logic [31:0] wpc, wtg; int cnt;
  } vec_t;

  vec_t tv[11];

  function automatic vec_t mk(logic ev, logic [31:0] ep, logic [31:0] et, logic iv,
                              logic [31:0] ip, logic [31:0] it, logic rex, logic rid,
                              logic wv, logic [31:0] wpc, logic [31:0] wtg, int cnt);
    vec_t v;
    v.ev = ev; v.ep = ep; v.et = et; v.iv = iv; v.ip = ip; v.it = it;
    v.rex = rex; v.rid = rid; v.wv = wv; v.wpc = wpc; v.wtg = wtg; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_rr = 0; m_drop = 0; m_wv = 1'b0; m_pc = '0; m_tgt = '0;
`ifdef BTB_UPD_DEDUP_EN
    m_last_v = 1'b0; m_last = '0;
`endif
  endfunction

  task automatic drive(input logic ev, input logic [31:0] ep, input logic [31:0] et,
                       input logic iv, input logic [31:0] ip, input logic [31:0] it,
                       input logic h, input logic f);
    ex_valid = ev; ex_pc = ep; ex_target = et;
    id_valid = iv; id_pc = ip; id_target = it;
    wr_hold = h; flush = f;
  endtask

  // One clock: check readies before the edge, advance model, check outputs after.
  task automatic cycle();
    logic g_ex, g_id, r_ex, r_id, pop;
    logic [63:0] e;
    @(negedge clk);
    g_ex = ex_valid && (!id_valid || m_rr == 0);
    g_id = id_valid && (!ex_valid || m_rr == 1);
    r_ex = g_ex && (m_q.size() < Depth) && !flush;
    r_id = g_id && (m_q.size() < Depth) && !flush;
    s_ex_rdy = ex_ready; s_id_rdy = id_ready;
    check("ex_ready", 64'(ex_ready), 64'(r_ex));
    check("id_ready", 64'(id_ready), 64'(r_id));
    pop = (m_q.size() > 0) && !wr_hold && !flush;
    m_wv = 1'b0;
    if (flush) begin
      m_q.delete();
`ifdef BTB_UPD_DEDUP_EN
      m_last_v = 1'b0;
`endif
    end else begin
      if (pop) begin
        e = m_q.pop_front();
        m_wv = 1'b1; m_pc = e[63:32]; m_tgt = e[31:0];
      end
      if (r_ex || r_id) begin
        e = r_ex ? {ex_pc, ex_target} : {id_pc, id_target};
        m_rr = 1 - m_rr;
`ifdef BTB_UPD_DEDUP_EN
        if (m_last_v && m_last == e) begin
          if (m_drop < MaxDrop) m_drop++;
        end else begin
          m_q.push_back(e); m_last_v = 1'b1; m_last = e;
        end
`else
        m_q.push_back(e);
`endif
      end
    end
    @(posedge clk);
    #1;
    check("btb_wr_valid", 64'(btb_wr_valid), 64'(m_wv));
    check("btb_wr_pc", 64'(btb_wr_pc), 64'(m_pc));
    check("btb_wr_target", 64'(btb_wr_target), 64'(m_tgt));
    check("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (btb_wr_valid === 1'b1) wr_pulses++;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Directed vectors: single request, then EX/ID contention from rr = EX.
    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    tv[1]  = mk(1, 32'h8000_0010, 32'h8000_0100, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1);
    tv[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0010, 32'h8000_0100, 0);
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0010, 32'h8000_0100, 0);
    tv[4]  = mk(0, 0, 0, 1, 32'h1000, 32'h2000, 0, 1, 0, 32'h8000_0010, 32'h8000_0100, 1);
    tv[5]  = mk(1, 32'h100, 32'h1100, 1, 32'h104, 32'h1104, 1, 0, 1, 32'h1000, 32'h2000, 1);
    tv[6]  = mk(1, 32'h108, 32'h1108, 1, 32'h10c, 32'h110c, 0, 1, 1, 32'h100, 32'h1100, 1);
    tv[7]  = mk(1, 32'h110, 32'h1110, 1, 32'h114, 32'h1114, 1, 0, 1, 32'h10c, 32'h110c, 1);
    tv[8]  = mk(1, 32'h118, 32'h1118, 1, 32'h11c, 32'h111c, 0, 1, 1, 32'h110, 32'h1110, 1);
    tv[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11c, 32'h111c, 0);
    tv[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11c, 32'h111c, 0);

    m_reset();
    #1;
    check("reset_wr_valid", 64'(btb_wr_valid), 64'd0);
    check("reset_wr_pc", 64'(btb_wr_pc), 64'd0);
    check("reset_count", 64'(fifo_count), 64'd0);
    check("reset_drop", 64'(drop_cnt), 64'd0);
    #21 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].ev, tv[i].ep, tv[i].et, tv[i].iv, tv[i].ip, tv[i].it, 0, 0);
      cycle();
      check($sformatf("vec%0d_ex_ready", i), 64'(s_ex_rdy), 64'(tv[i].rex));
      check($sformatf("vec%0d_id_ready", i), 64'(s_id_rdy), 64'(tv[i].rid));
      check($sformatf("vec%0d_wr_valid", i), 64'(btb_wr_valid), 64'(tv[i].wv));
      check($sformatf("vec%0d_wr_pc", i), 64'(btb_wr_pc), 64'(tv[i].wpc));
      check($sformatf("vec%0d_wr_target", i), 64'(btb_wr_target), 64'(tv[i].wtg));
      check($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(tv[i].cnt));
    end

    // Full while held: six EX requests, only four fit.
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h8000_0200 + 32'(i * 4), 32'h8000_1000 + 32'(i), 0, 0, 0, 1, 0);
      cycle();
    end
    check("full_count", 64'(fifo_count), 64'd4);
    check("full_ex_ready", 64'(s_ex_rdy), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("drain_pulse%0d", i), 64'(btb_wr_valid), 64'd1);
    end
    cycle();
    check("drain_done", 64'(btb_wr_valid), 64'd0);
    drive(1, 32'h8000_0300, 32'h8000_0400, 0, 0, 0, 0, 0);
    cycle();
    check("ready_after_drain", 64'(s_ex_rdy), 64'd1);
    idle(3);

    // Flush three held entries: nothing may drain afterwards.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h8000_0500 + 32'(i * 4), 32'h8000_0600, 0, 0, 0, 1, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    cycle();
    check("flush_count", 64'(fifo_count), 64'd0);
    wr_pulses = 0;
    idle(5);
    check("flush_no_write", 64'(wr_pulses), 64'd0);

    // Asynchronous reset with two entries buffered.
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h8000_0700 + 32'(i * 4), 32'h8000_0800, 0, 0, 0, 1, 0);
      cycle();
    end
    #2 rst = 1'b0;
    #1;
    check("arst_wr_valid", 64'(btb_wr_valid), 64'd0);
    check("arst_wr_pc", 64'(btb_wr_pc), 64'd0);
    check("arst_wr_target", 64'(btb_wr_target), 64'd0);
    check("arst_count", 64'(fifo_count), 64'd0);
    check("arst_drop", 64'(drop_cnt), 64'd0);
    m_reset();
    #1 rst = 1'b1;
    wr_pulses = 0;
    idle(5);
    check("arst_no_write", 64'(wr_pulses), 64'd0);

    // Same update accepted twice back-to-back.
    wr_pulses = 0;
    drive(1, 32'h8000_0043, 32'h8000_0400, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    idle(4);
`ifdef BTB_UPD_DEDUP_EN
    check("dup_writes", 64'(wr_pulses), 64'd1);
    check("dup_drop_cnt", 64'(drop_cnt), 64'd1);
`else
    check("dup_writes", 64'(wr_pulses), 64'd2);
    check("dup_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

    // Randomized traffic against the model; small pc pool provokes duplicates.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), 32'h8000_0000 | 32'($urandom_range(0, 7)),
            32'h9000_0000 | 32'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 32'h8000_0000 | 32'($urandom_range(0, 7)),
            32'h9000_0000 | 32'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
      cycle();
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
